// File: rtl/avalon_arb_pkg.sv
// ============================================================================
// Module      : avalon_arb_pkg
// Description : Shared state encoding and constants for avalon_mm_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package avalon_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Wide enough for any WIDTH up to 64; the top slices off what it needs.
  localparam logic [63:0] C_ERR_DATA        = '1;
  localparam int          C_TIMEOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/avalon_mm_arbiter_rr2.sv
// ============================================================================
// Module      : arb_rr2
// Description : Two-way round-robin grant with last-grant register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // High when requester 1 holds the most recent grant.
  logic r_last;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || r_last)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (update) begin
      r_last <= grant[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/avalon_mm_arbiter.sv
// ============================================================================
// Module      : avalon_mm_arbiter
// Description : Two-requester round-robin arbiter onto one Avalon-MM master.
//               Optional ACCESS timeout enabled by `define ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_mm_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [1:0]         start,
  input  logic [1:0]         rnw,
  input  logic [2*WIDTH-1:0] address_to_access,
  input  logic [2*WIDTH-1:0] data_to_write,
  output logic [WIDTH-1:0]   data_read,
  output logic [1:0]         done,
  output logic               err,
  output logic [WIDTH-1:0]   ADDRESS,
  output logic               BEGINTRANSFER,
  output logic               READ,
  output logic               WRITE,
  output logic [WIDTH-1:0]   WRITEDATA,
  output logic               LOCK,
  input  logic [WIDTH-1:0]   READDATA,
  input  logic               WAITREQUEST
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_RESP   = ST_RESP;

  logic [1:0] r_state;
  logic [1:0] r_gnt;
  logic [1:0] w_grant;
  logic       w_sel;
  logic       w_accept;
  logic       w_abort;

  assign w_accept = (r_state == S_IDLE) && (|start);
  assign w_sel    = w_grant[1];
  assign LOCK     = 1'b0;

  arb_rr2 u_arb_rr2 (
    .clk    (CLK),
    .rst_n  (RST_N),
    .req    (start),
    .update (w_accept),
    .grant  (w_grant)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int C_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_err;

  // Counter reads 0 in the first ACCESS cycle, so TIMEOUT-1 marks the last allowed one.
  assign w_abort = (r_state == S_ACCESS) && WAITREQUEST && (r_cnt == C_CNT_W'(TIMEOUT - 1));
  assign err     = r_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (r_state != S_ACCESS) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT;
  assign w_abort          = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= S_IDLE;
      r_gnt         <= 2'b00;
      data_read     <= '0;
      done          <= 2'b00;
      ADDRESS       <= '0;
      WRITEDATA     <= '0;
      BEGINTRANSFER <= 1'b0;
      READ          <= 1'b0;
      WRITE         <= 1'b0;
    end else begin
      BEGINTRANSFER <= 1'b0;
      done          <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state       <= S_ACCESS;
            r_gnt         <= w_grant;
            BEGINTRANSFER <= 1'b1;
            READ          <= rnw[w_sel];
            WRITE         <= ~rnw[w_sel];
            ADDRESS       <= w_sel ? address_to_access[2*WIDTH-1:WIDTH] : address_to_access[WIDTH-1:0];
            WRITEDATA     <= w_sel ? data_to_write[2*WIDTH-1:WIDTH] : data_to_write[WIDTH-1:0];
          end
        end
        S_ACCESS: begin
          if (!WAITREQUEST) begin
            r_state <= S_RESP;
            READ    <= 1'b0;
            WRITE   <= 1'b0;
            done    <= r_gnt;
            if (READ) begin
              data_read <= READDATA;
            end
          end else if (w_abort) begin
            r_state   <= S_RESP;
            READ      <= 1'b0;
            WRITE     <= 1'b0;
            done      <= r_gnt;
            data_read <= C_ERR_DATA[WIDTH-1:0];
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/avalon_mm_arbiter.md
AVALON_MM_ARBITER -- requirements
Module: avalon_mm_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum ACCESS cycles before abort; used only with ARB_TIMEOUT_EN.
REQ-003 SHALL have port CLK, in, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, in, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, in, 2, per-requester level request; bit0 instr, bit1 data.
REQ-006 SHALL have port rnw, in, 2, per-requester direction; 1 read, 0 write.
REQ-007 SHALL have port address_to_access, in, 2*WIDTH, packed per-requester address; requester 0 in the low half.
REQ-008 SHALL have port data_to_write, in, 2*WIDTH, packed per-requester write data.
REQ-009 SHALL have port data_read, out, WIDTH, registered read data, shared by both requesters.
REQ-010 SHALL have port done, out, 2, one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port err, out, 1, one-cycle timeout pulse, coincident with done.
REQ-012 SHALL have ports ADDRESS (out, WIDTH), BEGINTRANSFER (out, 1), READ (out, 1), WRITE (out, 1), WRITEDATA (out, WIDTH) and LOCK (out, 1), forming the Avalon-MM master.
REQ-013 SHALL have ports READDATA (in, WIDTH) and WAITREQUEST (in, 1), completing the Avalon-MM master.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-015 SHALL sample start only in IDLE: any bit high -> latch the winner's rnw, address and wdata -> ACCESS on the next edge.
REQ-016 SHALL arbitrate round-robin: on a single request, grant that requester; on both, grant the requester not granted last.
REQ-017 SHALL drive BEGINTRANSFER high for exactly the first ACCESS cycle.
REQ-018 SHALL hold READ=rnw and WRITE=~rnw, with ADDRESS/WRITEDATA stable from the latched values, throughout ACCESS.
REQ-019 SHALL leave ACCESS on the first edge where WAITREQUEST=0, capture READDATA into data_read on reads, and enter RESP.
REQ-020 SHALL leave data_read unchanged on writes.
REQ-021 SHALL in RESP hold READ/WRITE low, pulse done[granted] for one cycle, then go to IDLE.
REQ-022 SHALL achieve a minimum latency of start sampled at edge k -> done high in cycle k+2; a back-to-back request is re-arbitrated at edge k+3.
REQ-023 SHALL drop a start deasserted while IDLE without side effect; start changes during ACCESS/RESP are ignored.
REQ-024 SHALL tie LOCK to 0.
REQ-025 SHALL never assert READ and WRITE simultaneously.

Reset
REQ-026 SHALL on RST_N low, asynchronously: state=IDLE, last-grant=requester 1 (so requester 0 wins the first tie), data_read=0, done=0, err=0, ADDRESS=0, WRITEDATA=0, BEGINTRANSFER=0, READ=0, WRITE=0.
REQ-027 SHALL abandon a reset asserted mid-ACCESS immediately, with no done pulse.

Configuration
REQ-028 SHALL, when ARB_TIMEOUT_EN is defined, count ACCESS cycles; if WAITREQUEST is still high after TIMEOUT cycles, drop READ/WRITE and enter RESP with done[granted]=1, err=1 and data_read=all-ones.
REQ-029 SHALL, when ARB_TIMEOUT_EN is undefined, wait in ACCESS indefinitely, tie err to 0 and contain no counter.

Structure
REQ-030 SHALL take its state enum, the all-ones error-data constant and the TIMEOUT default from package avalon_arb_pkg.
REQ-031 SHALL instantiate sub-module arb_rr2, holding the two-way round-robin grant logic and the last-grant register.

Verification
REQ-032 SHALL cover: start=01, read, addr 0x10, WAITREQUEST=0 -> BEGINTRANSFER one cycle, READ=1, ADDRESS=0x10, done=01 two cycles after sampling, data_read=READDATA.
REQ-033 SHALL cover: start=10, write, wdata 0xCAFEF00D, WAITREQUEST high 3 cycles -> WRITE held 4 cycles, WRITEDATA stable, done=10 once, data_read unchanged.
REQ-034 SHALL cover: start=11 held after reset -> grants alternate 0,1,0,1 over four transfers.
REQ-035 SHALL cover: RST_N low during ACCESS -> all outputs reset asynchronously, no done pulse, IDLE after release.
REQ-036 SHALL cover: with ARB_TIMEOUT_EN and TIMEOUT=4, WAITREQUEST stuck high -> READ drops after 4 ACCESS cycles, done and err pulse together, data_read=0xFFFFFFFF.
REQ-037 SHALL cover: without ARB_TIMEOUT_EN, WAITREQUEST high for 300 cycles then low -> a single completion, err never high.
